// File: rtl/addr_sequencer.sv
// Bus-cycle sequencer granting the memory address bus to PC (fetch) or XP (block transfer),
// one word per cycle, with a bounded transfer burst while a fetch is waiting.
module addr_sequencer #(
  parameter int LEN_W = 8,
  parameter int BURST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_FETCH,
  input  logic             XFER_START,
  input  logic [LEN_W-1:0] XFER_LEN,
  input  logic             XFER_WR,
  output logic             PC_ASSERT_bar,
  output logic             PC_INC,
  output logic             XP_ASSERT_bar,
  output logic             XP_INC,
  output logic             MEM_RD_bar,
  output logic             MEM_WR_bar,
  output logic             GNT_FETCH,
  output logic             FETCH_PEND,
  output logic             XFER_BUSY,
  output logic             XFER_DONE
);

  localparam int               CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               fetch_pend;
  logic               xfer_busy;
  logic               xfer_done;
  logic               xfer_wr_q;
  logic [LEN_W-1:0]   xfer_rem;
  logic [CNT_W-1:0]   burst_cnt;

  logic accept;
  logic last_word;
  logic xa;
  logic fp;
  logic enter_fetch;
  logic enter_xfer;

  // A fetch pending flag that is already being served this cycle does not request another word.
  assign accept      = XFER_START & ~xfer_busy;
  assign last_word   = (state == S_XFER) && (xfer_rem == LEN_W'(1));
  assign xa          = accept | (xfer_busy & ~last_word);
  assign fp          = REQ_FETCH | (fetch_pend & (state != S_FETCH));
  assign enter_fetch = (state_nxt == S_FETCH);
  assign enter_xfer  = (state_nxt == S_XFER);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    if (xa && (burst_cnt < BURST_C)) state_nxt = S_XFER;
    else if (fp)                     state_nxt = S_FETCH;
    else if (xa)                     state_nxt = S_XFER;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pend <= 1'b0;
      xfer_busy  <= 1'b0;
      xfer_done  <= 1'b0;
      xfer_wr_q  <= 1'b0;
      xfer_rem   <= '0;
      burst_cnt  <= '0;
    end else begin
      fetch_pend <= REQ_FETCH | (fetch_pend & ~enter_fetch & (state != S_FETCH));
      xfer_busy  <= xa;
      xfer_done  <= xfer_busy & last_word;
      if (accept) begin
        xfer_rem  <= XFER_LEN;
        xfer_wr_q <= XFER_WR;
      end else if (state == S_XFER) begin
        xfer_rem  <= xfer_rem - LEN_W'(1);
      end
      // A start that also enters XFER counts that first word toward the burst.
      if (enter_fetch)
        burst_cnt <= '0;
      else if (enter_xfer)
        burst_cnt <= accept ? CNT_W'(1)
                   : (burst_cnt < BURST_C) ? burst_cnt + CNT_W'(1) : burst_cnt;
      else if (accept)
        burst_cnt <= '0;
    end
  end

  assign PC_ASSERT_bar = ~(state == S_FETCH);
  assign PC_INC        =  (state == S_FETCH);
  assign GNT_FETCH     =  (state == S_FETCH);
  assign XP_ASSERT_bar = ~(state == S_XFER);
  assign XP_INC        =  (state == S_XFER);
  assign MEM_RD_bar    = ~((state == S_FETCH) | ((state == S_XFER) & ~xfer_wr_q));
  assign MEM_WR_bar    = ~((state == S_XFER) & xfer_wr_q);
  assign FETCH_PEND    = fetch_pend;
  assign XFER_BUSY     = xfer_busy;
  assign XFER_DONE     = xfer_done;

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed bench for addr_sequencer: reset, fetch, transfers, arbitration, wrap and abort.
module tb_addr_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_FETCH;
  logic       XFER_START;
  logic [7:0] XFER_LEN;
  logic       XFER_WR;
  logic       PC_ASSERT_bar, PC_INC, XP_ASSERT_bar, XP_INC;
  logic       MEM_RD_bar, MEM_WR_bar, GNT_FETCH, FETCH_PEND, XFER_BUSY, XFER_DONE;

  int checks = 0;
  int errors = 0;

  // {PC_A_bar, PC_INC, XP_A_bar, XP_INC, RD_bar, WR_bar, GNT, PEND, BUSY, DONE}
  localparam logic [9:0] IDLE_V  = 10'b1010110000;
  localparam logic [9:0] FETCH_V = 10'b0110011000;
  localparam logic [9:0] XW_V    = 10'b1001100000;
  localparam logic [9:0] XR_V    = 10'b1001010000;
  localparam logic [9:0] PEND    = 10'b0000000100;
  localparam logic [9:0] BUSY    = 10'b0000000010;
  localparam logic [9:0] DONE    = 10'b0000000001;

  logic [9:0] obs;
  assign obs = {PC_ASSERT_bar, PC_INC, XP_ASSERT_bar, XP_INC, MEM_RD_bar, MEM_WR_bar,
                GNT_FETCH, FETCH_PEND, XFER_BUSY, XFER_DONE};

  addr_sequencer #(.LEN_W(8), .BURST(4)) dut (
    .CLK(CLK), .RST(RST), .REQ_FETCH(REQ_FETCH), .XFER_START(XFER_START),
    .XFER_LEN(XFER_LEN), .XFER_WR(XFER_WR),
    .PC_ASSERT_bar(PC_ASSERT_bar), .PC_INC(PC_INC),
    .XP_ASSERT_bar(XP_ASSERT_bar), .XP_INC(XP_INC),
    .MEM_RD_bar(MEM_RD_bar), .MEM_WR_bar(MEM_WR_bar),
    .GNT_FETCH(GNT_FETCH), .FETCH_PEND(FETCH_PEND),
    .XFER_BUSY(XFER_BUSY), .XFER_DONE(XFER_DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_FETCH = 1'b0; XFER_START = 1'b0; XFER_LEN = '0; XFER_WR = 1'b0;
    #3;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL reset_async: got %b want %b", obs, IDLE_V);
    end
    step(); step();
    RST = 1'b0;
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL reset_release: got %b want %b", obs, IDLE_V);
    end
  endtask

  task automatic test_single_fetch();
    REQ_FETCH = 1'b1;
    step();
    REQ_FETCH = 1'b0;
    checks++;
    if (obs !== (FETCH_V | PEND)) begin
      errors++; $display("FAIL fetch_c1: got %b want %b", obs, FETCH_V | PEND);
    end
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL fetch_c2: got %b want %b", obs, IDLE_V);
    end
  endtask

  task automatic test_write_xfer();
    XFER_START = 1'b1; XFER_LEN = 8'd3; XFER_WR = 1'b1;
    step();
    // a start while busy must be ignored, length and direction not resampled
    XFER_LEN = 8'd1; XFER_WR = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (obs !== (XW_V | BUSY)) begin
        errors++; $display("FAIL wr_xfer_c%0d: got %b want %b", k, obs, XW_V | BUSY);
      end
      step();
      XFER_START = 1'b0;
    end
    checks++;
    if (obs !== (IDLE_V | DONE)) begin
      errors++; $display("FAIL wr_xfer_done: got %b want %b", obs, IDLE_V | DONE);
    end
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL wr_xfer_after: got %b want %b", obs, IDLE_V);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_t [1:6];
    exp_t = '{XR_V | BUSY, XR_V | BUSY, IDLE_V | DONE, XW_V | BUSY, IDLE_V | DONE, IDLE_V};
    XFER_START = 1'b1; XFER_LEN = 8'd2; XFER_WR = 1'b0;
    step();
    XFER_START = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (obs !== exp_t[k]) begin
        errors++; $display("FAIL b2b_c%0d: got %b want %b", k, obs, exp_t[k]);
      end
      if (k == 3) begin
        XFER_START = 1'b1; XFER_LEN = 8'd1; XFER_WR = 1'b1;
      end else begin
        XFER_START = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_contention();
    logic [9:0] exp_t [1:15];
    exp_t = '{XR_V | BUSY | PEND, XR_V | BUSY | PEND, XR_V | BUSY | PEND, XR_V | BUSY | PEND,
              FETCH_V | BUSY | PEND,
              XR_V | BUSY | PEND, XR_V | BUSY | PEND, XR_V | BUSY | PEND, XR_V | BUSY | PEND,
              FETCH_V | BUSY | PEND,
              XR_V | BUSY | PEND, XR_V | BUSY | PEND,
              FETCH_V | PEND | DONE, FETCH_V | PEND, IDLE_V};
    XFER_START = 1'b1; XFER_LEN = 8'd10; XFER_WR = 1'b0; REQ_FETCH = 1'b1;
    step();
    XFER_START = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if (obs !== exp_t[k]) begin
        errors++; $display("FAIL contention_c%0d: got %b want %b", k, obs, exp_t[k]);
      end
      if (k == 14) REQ_FETCH = 1'b0;
      step();
    end
  endtask

  task automatic test_merge_pulse();
    logic [9:0] exp_t [1:9];
    exp_t = '{XW_V | BUSY | PEND, XW_V | BUSY | PEND, XW_V | BUSY | PEND, XW_V | BUSY | PEND,
              FETCH_V | BUSY, XW_V | BUSY, XW_V | BUSY, IDLE_V | DONE, IDLE_V};
    XFER_START = 1'b1; XFER_LEN = 8'd6; XFER_WR = 1'b1; REQ_FETCH = 1'b1;
    step();
    XFER_START = 1'b0; REQ_FETCH = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (obs !== exp_t[k]) begin
        errors++; $display("FAIL merge_c%0d: got %b want %b", k, obs, exp_t[k]);
      end
      REQ_FETCH = (k == 2);
      step();
    end
    REQ_FETCH = 1'b0;
  endtask

  task automatic test_wrap_len();
    int bad = 0;
    XFER_START = 1'b1; XFER_LEN = 8'd0; XFER_WR = 1'b1;
    step();
    XFER_START = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      checks++;
      if (obs !== (XW_V | BUSY)) begin
        errors++; bad++;
        if (bad <= 4) $display("FAIL wrap_c%0d: got %b want %b", k, obs, XW_V | BUSY);
      end
      step();
    end
    checks++;
    if (obs !== (IDLE_V | DONE)) begin
      errors++; $display("FAIL wrap_done: got %b want %b", obs, IDLE_V | DONE);
    end
    step();
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL wrap_after: got %b want %b", obs, IDLE_V);
    end
  endtask

  task automatic test_reset_mid_xfer();
    XFER_START = 1'b1; XFER_LEN = 8'd5; XFER_WR = 1'b1;
    step();
    XFER_START = 1'b0;
    step(); step();
    checks++;
    if (obs !== (XW_V | BUSY)) begin
      errors++; $display("FAIL abort_pre: got %b want %b", obs, XW_V | BUSY);
    end
    #3 RST = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL abort_immediate: got %b want %b", obs, IDLE_V);
    end
    step();
    RST = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (obs !== IDLE_V) begin
        errors++; $display("FAIL abort_idle_c%0d: got %b want %b", k, obs, IDLE_V);
      end
    end
    XFER_START = 1'b1; XFER_LEN = 8'd1; XFER_WR = 1'b0;
    step();
    XFER_START = 1'b0;
    checks++;
    if (obs !== (XR_V | BUSY)) begin
      errors++; $display("FAIL abort_restart: got %b want %b", obs, XR_V | BUSY);
    end
    step();
    checks++;
    if (obs !== (IDLE_V | DONE)) begin
      errors++; $display("FAIL abort_restart_done: got %b want %b", obs, IDLE_V | DONE);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_xfer();
    test_back_to_back();
    test_contention();
    test_merge_pulse();
    test_wrap_len();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Bus-cycle sequencer for the two 16-bit address registers: program counter (PC) and transfer pointer (XP).
- Each cycle it grants the memory address bus to at most one register. It drives that register's ASSERT_bar and INC strobes and the memory read/write strobes.
- Arbitrates single-word instruction fetches against multi-word block transfers, with a bounded burst so fetch latency stays capped.
- Sits between the control unit / block-copy requester and the PC/XP register pair.

Parameters:
LEN_W, 8, width of transfer length and remaining-word counter
BURST, 4, max consecutive XFER words while a fetch is pending (>=1)

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  asynchronous, active-high reset
REQ_FETCH  input  1  one-word fetch request strobe
XFER_START  input  1  block transfer start strobe; ignored while XFER_BUSY=1
XFER_LEN  input  LEN_W  word count, sampled with XFER_START; 0 means 2^LEN_W
XFER_WR  input  1  direction, sampled with XFER_START: 1 write, 0 read
PC_ASSERT_bar  output  1  PC drives address bus (active low)
PC_INC  output  1  PC increments at end of cycle
XP_ASSERT_bar  output  1  XP drives address bus (active low)
XP_INC  output  1  XP increments at end of cycle
MEM_RD_bar  output  1  memory read strobe (active low)
MEM_WR_bar  output  1  memory write strobe (active low)
GNT_FETCH  output  1  current cycle is the granted fetch word
FETCH_PEND  output  1  fetch request accepted but not yet issued
XFER_BUSY  output  1  transfer accepted and not complete
XFER_DONE  output  1  one-cycle pulse after last transfer word

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values: state=IDLE; all _bar outputs=1; PC_INC, XP_INC, GNT_FETCH, FETCH_PEND, XFER_BUSY, XFER_DONE=0; fetch_pend=0; xfer_rem=0; burst_cnt=0.
- Reset mid-operation: outputs go inactive immediately. The transfer is abandoned: no DONE pulse and no resumption after release.
- Moore outputs: all outputs decode from registered state, so they are glitch-free.
- States:
  - IDLE: all outputs inactive.
  - FETCH: PC_ASSERT_bar=0, PC_INC=1, MEM_RD_bar=0, GNT_FETCH=1.
  - XFER: XP_ASSERT_bar=0, XP_INC=1. MEM_WR_bar=0 if the latched direction is write, else MEM_RD_bar=0.
- Each state lasts exactly one cycle (one bus word). Next state is chosen at every edge.
- Effective inputs at each edge:
  - fp = fetch_pend OR REQ_FETCH.
  - xa = XFER_BUSY, or XFER_START accepted this edge. xa is cleared by the word with xfer_rem==1 completing.
- Next-state priority:
  1. xa and burst_cnt<BURST → XFER.
  2. else fp → FETCH.
  3. else xa → XFER.
  4. else IDLE.
- Latency: a strobe in cycle k yields its bus word in cycle k+1 at the earliest.
- fetch_pend:
  - Set by REQ_FETCH.
  - Cleared at the edge that enters FETCH, unless REQ_FETCH is also high at that edge.
  - Strobes while already pending merge into one request.
- burst_cnt:
  - Cleared on XFER_START acceptance and on every edge entering FETCH.
  - Increments on every edge entering XFER; saturates at BURST.
- xfer_rem:
  - Loaded with XFER_LEN on start.
  - Decrements (mod 2^LEN_W) at the end of each XFER cycle.
  - The word executed with xfer_rem==1 is the last. LEN=0 wraps and gives 2^LEN_W words.
- XFER_BUSY: 1 from the cycle after start through the last XFER cycle.
- XFER_DONE: 1 for exactly the following cycle. XFER_BUSY=0 in that cycle, so a new XFER_START is accepted there.
- Simultaneous REQ_FETCH and XFER_START in IDLE: the XFER word goes first (burst_cnt=0). The fetch is served after BURST words or on completion, whichever comes first.
- XFER_START while busy: ignored; XFER_LEN and XFER_WR are not resampled.
- No bus contention: at most one of PC_ASSERT_bar and XP_ASSERT_bar is low in any cycle. MEM_RD_bar and MEM_WR_bar are never low together.

Test Plan:
- Reset: assert RST mid-cycle → all _bar=1, all INC/GNT/BUSY/DONE=0 immediately, state IDLE.
- Single fetch: REQ_FETCH pulse in cycle 0 → cycle 1: PC_ASSERT_bar=0, PC_INC=1, MEM_RD_bar=0, GNT_FETCH=1; cycle 2 IDLE; FETCH_PEND=1 only in cycle 1.
- Write transfer: XFER_START, XFER_LEN=3, XFER_WR=1 in cycle 0 → cycles 1-3: XP_ASSERT_bar=0, XP_INC=1, MEM_WR_bar=0, XFER_BUSY=1; cycle 4: XFER_DONE=1, XFER_BUSY=0.
- Contention (BURST=4): XFER_START LEN=10 in cycle 0, REQ_FETCH held high from cycle 0 → cycles 1-4 XFER, 5 FETCH, 6-9 XFER, 10 FETCH, 11-12 XFER, 13 FETCH with XFER_DONE=1, then FETCH every cycle.
- Wrap length: LEN_W=8, XFER_LEN=0 → exactly 256 XFER cycles (1-256), XFER_DONE in cycle 257.
- Reset mid-transfer: XFER LEN=5 started in cycle 0, RST pulsed in cycle 3 → outputs inactive at once. After release: no XFER cycles, XFER_DONE never pulses, and a new XFER_START is accepted.
